// File: rtl/iir_mac_scheduler.sv
// Round-robin scheduler sharing one 4x4 signed multiplier and adder across NCH first-order IIR channels.
// Optional build macro IIR_SAT_EN: saturate the product and the sum to [-8,7] instead of wrapping.
module iir_mac_scheduler #(
  parameter int NCH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req_valid,
  output logic [NCH-1:0]   req_ready,
  input  logic [4*NCH-1:0] x_in,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_ch,
  input  logic [3:0]       cfg_a,
  output logic             out_valid,
  output logic [2:0]       out_ch,
  output logic [3:0]       out_y,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_MUL, S_ACC} state_t;

  state_t            state_q, state_d;
  logic [2:0]        rr_q, rr_d;
  logic [2:0]        g_q, g_d;
  logic [3:0]        x_q, x_d;
  logic signed [3:0] coef_cur_q, coef_cur_d;
  logic signed [7:0] p_q, p_d;
  logic [3:0]        y_hold_q, y_hold_d;
  logic [2:0]        ch_hold_q, ch_hold_d;

  // Banks are sized for the 8-channel maximum so a 3-bit index is always exact;
  // entries at or above NCH are never written and stay at their reset value.
  logic signed [3:0] coef_q [8];
  logic signed [3:0] coef_d [8];
  logic signed [3:0] ystate_q [8];
  logic signed [3:0] ystate_d [8];

  logic [7:0]        valid_pad;
  logic [31:0]       x_pad;
  logic [3:0]        cand;
  logic [2:0]        gsel;
  logic              found;
  logic [3:0]        sum;
  logic signed [3:0] ycur;

  assign valid_pad = 8'(req_valid);
  assign x_pad     = 32'(x_in);
  assign ycur      = ystate_q[g_q];

  // Round-robin search starting at rr_q, wrapping at NCH.
  always_comb begin
    found = 1'b0;
    gsel  = 3'd0;
    cand  = 4'd0;
    for (int k = 0; k < NCH; k++) begin
      cand = {1'b0, rr_q} + 4'(k);
      if (cand >= 4'(NCH)) cand = cand - 4'(NCH);
      if (!found && valid_pad[cand[2:0]]) begin
        found = 1'b1;
        gsel  = cand[2:0];
      end
    end
  end

`ifdef IIR_SAT_EN
  logic signed [3:0] p_sat;
  logic signed [4:0] s5;
  always_comb begin
    if (p_q > 8'sd7)       p_sat = 4'b0111;
    else if (p_q < -8'sd8) p_sat = 4'b1000;
    else                   p_sat = p_q[3:0];
    s5 = {x_q[3], x_q} + {p_sat[3], p_sat};
    if (s5 > 5'sd7)        sum = 4'b0111;
    else if (s5 < -5'sd8)  sum = 4'b1000;
    else                   sum = s5[3:0];
  end
`else
  logic unused_p_hi;
  assign unused_p_hi = ^p_q[7:4];
  always_comb begin
    sum = x_q + p_q[3:0];
  end
`endif

  // FSM state register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_q       <= 3'd0;
      g_q        <= 3'd0;
      x_q        <= 4'd0;
      coef_cur_q <= 4'sd0;
      p_q        <= 8'sd0;
      y_hold_q   <= 4'd0;
      ch_hold_q  <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        coef_q[i]   <= 4'sd0;
        ystate_q[i] <= 4'sd0;
      end
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      g_q        <= g_d;
      x_q        <= x_d;
      coef_cur_q <= coef_cur_d;
      p_q        <= p_d;
      y_hold_q   <= y_hold_d;
      ch_hold_q  <= ch_hold_d;
      for (int i = 0; i < 8; i++) begin
        coef_q[i]   <= coef_d[i];
        ystate_q[i] <= ystate_d[i];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|req_valid) state_d = S_GRANT;
      S_GRANT: state_d = found ? S_MUL : S_IDLE;
      S_MUL:   state_d = S_ACC;
      S_ACC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rr_d       = rr_q;
    g_d        = g_q;
    x_d        = x_q;
    coef_cur_d = coef_cur_q;
    p_d        = p_q;
    y_hold_d   = y_hold_q;
    ch_hold_d  = ch_hold_q;
    for (int i = 0; i < 8; i++) begin
      coef_d[i]   = coef_q[i];
      ystate_d[i] = ystate_q[i];
      if (cfg_we && ({1'b0, cfg_ch} < 4'(NCH)) && (cfg_ch == 3'(i))) coef_d[i] = cfg_a;
    end
    case (state_q)
      S_GRANT: if (found) begin
        g_d  = gsel;
        x_d  = x_pad[{gsel, 2'b00} +: 4];
        rr_d = (gsel == 3'(NCH - 1)) ? 3'd0 : gsel + 3'd1;
        // A write landing on the same edge must reach this multiply, so forward it.
        coef_cur_d = (cfg_we && (cfg_ch == gsel)) ? cfg_a : coef_q[gsel];
      end
      S_MUL: p_d = {{4{coef_cur_q[3]}}, coef_cur_q} * {{4{ycur[3]}}, ycur};
      S_ACC: begin
        ystate_d[g_q] = sum;
        y_hold_d      = sum;
        ch_hold_d     = g_q;
      end
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      req_ready[i] = (state_q == S_GRANT) && found && (gsel == 3'(i));
    end
    out_valid = (state_q == S_ACC);
    out_ch    = (state_q == S_ACC) ? g_q : ch_hold_q;
    out_y     = (state_q == S_ACC) ? sum : y_hold_q;
    busy      = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_iir_mac_scheduler.sv
// Scoreboard bench for iir_mac_scheduler: expected results queued at stimulus time, checked on out_valid.
module tb_iir_mac_scheduler;
  localparam int NCH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   req_valid;
  logic [NCH-1:0]   req_ready;
  logic [4*NCH-1:0] x_in;
  logic             cfg_we;
  logic [2:0]       cfg_ch;
  logic [3:0]       cfg_a;
  logic             out_valid;
  logic [2:0]       out_ch;
  logic [3:0]       out_y;
  logic             busy;

  iir_mac_scheduler #(.NCH(NCH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .x_in(x_in),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_a(cfg_a), .out_valid(out_valid),
    .out_ch(out_ch), .out_y(out_y), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int ch; int y;} exp_t;
  exp_t           sb[$];
  exp_t           e;
  int             gl_ch[$];
  int             gl_cyc[$];
  int             total = 0;
  int             bad = 0;
  int             cyc = 0;
  int             last_gcyc = -100;
  logic [NCH-1:0] hs_pend = '0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requesters drop valid right after their handshake edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (hs_pend[i]) begin
        req_valid[i] = 1'b0;
        hs_pend[i]   = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if ((req_ready & req_valid) != '0) begin
        chk("ready_onehot", $countones(req_ready), 1);
        for (int i = 0; i < NCH; i++) begin
          if (req_ready[i]) begin
            gl_ch.push_back(i);
            gl_cyc.push_back(cyc);
            last_gcyc  = cyc;
            hs_pend[i] = 1'b1;
            $display("grant ch=%0d cyc=%0d", i, cyc);
          end
        end
      end
      if (out_valid) begin
        chk("out_lat", cyc - last_gcyc, 2);
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          $display("result ch=%0d y=%0d exp_ch=%0d exp_y=%0d", out_ch, out_y, e.ch, e.y);
          chk("out_ch", int'(out_ch), e.ch);
          chk("out_y", int'(out_y), e.y);
        end
      end
    end
  end

  task automatic push_exp(input int ch, input int y);
    exp_t t;
    t.ch = ch;
    t.y  = y;
    sb.push_back(t);
  endtask

  task automatic raise(input int ch, input int x);
    x_in[4*ch +: 4] = 4'(x);
    req_valid[ch]   = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk(tag, sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic send(input int ch, input int x, input int y);
    push_exp(ch, y);
    raise(ch, x);
    wait_drain("send_timeout");
  endtask

  task automatic cfg_write(input int ch, input int a);
    cfg_ch = 3'(ch);
    cfg_a  = 4'(a);
    cfg_we = 1'b1;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic wait_grant(input int ch, input string tag);
    int n = 0;
    while (!req_ready[ch] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[ch]) chk(tag, 0, 1);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    cfg_we    = 1'b0;
    hs_pend   = '0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int rec_exp[4];

  initial begin
    rst = 1'b1; req_valid = '0; x_in = '0; cfg_we = 1'b0; cfg_ch = 3'd0; cfg_a = 4'd0;
    #1;
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_out_y", int'(out_y), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset during MUL drops the sample and clears ystate
    send(0, 5, 5);
    cfg_write(0, 1);
    raise(0, 0);
    wait_grant(0, "mulrst_grant_timeout");
    @(posedge clk);
    #2;
    chk("mulrst_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mulrst_busy", int'(busy), 0);
    chk("mulrst_out_valid", int'(out_valid), 0);
    chk("mulrst_out_y", int'(out_y), 0);
    chk("mulrst_ready", int'(req_ready), 0);
    @(negedge clk);
    req_valid = '0;
    hs_pend   = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    cfg_write(0, 1);
    send(0, 0, 0);

    // Recurrence on channel 0 with a=2
`ifdef IIR_SAT_EN
    rec_exp = '{1, 3, 7, 7};
`else
    rec_exp = '{1, 3, 7, 15};
`endif
    cfg_write(0, 2);
    for (int k = 0; k < 4; k++) send(0, 1, rec_exp[k]);

    // Negative coefficient on channel 1
    cfg_write(1, 15);
    send(1, 3, 3);
    send(1, 0, 13);

    // Arbitration with all channels requesting
    do_reset();
    chk("arb_idle_busy", int'(busy), 0);
    gl_ch.delete();
    gl_cyc.delete();
    for (int ch = 0; ch < NCH; ch++) begin
      push_exp(ch, ch + 1);
      raise(ch, ch + 1);
    end
    wait_drain("arb_timeout");
    chk("arb_count", gl_ch.size(), NCH);
    for (int k = 0; k < NCH && k < gl_ch.size(); k++) begin
      chk("arb_ch", gl_ch[k], k);
      chk("arb_cyc", gl_cyc[k] - gl_cyc[0], 4 * k);
    end
    gl_ch.delete();
    gl_cyc.delete();
    push_exp(0, 6);
    push_exp(2, 5);
    raise(2, 5);
    raise(0, 6);
    wait_drain("rearb_timeout");
    chk("rearb_first", (gl_ch.size() > 0) ? gl_ch[0] : -1, 0);

    // Coefficient write in the GRANT cycle is used by that multiply
    do_reset();
    cfg_write(0, 1);
    send(0, 2, 2);
    raise(0, 0);
    push_exp(0, 6);
    wait_grant(0, "race_grant_timeout");
    cfg_ch = 3'd0;
    cfg_a  = 4'd3;
    cfg_we = 1'b1;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    wait_drain("race_timeout");

    // Coefficient write in the MUL cycle waits for the next sample
    do_reset();
    cfg_write(0, 1);
    send(0, 2, 2);
    raise(0, 0);
    push_exp(0, 2);
    wait_grant(0, "race2_grant_timeout");
    @(posedge clk);
    #1;
    cfg_ch = 3'd0;
    cfg_a  = 4'd3;
    cfg_we = 1'b1;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    wait_drain("race2_timeout");
    send(0, 0, 6);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iir_mac_scheduler.md
# iir_mac_scheduler

Time-multiplexed controller for a bank of first-order IIR channels, y[n] = x[n] + a·y[n-1], sharing one 4x4 signed multiplier and one adder. Round-robin arbitration picks one requesting channel at a time and sequences it through multiply and accumulate. The block holds per-channel coefficient and state registers. It sits between the sample sources and the downstream consumer, and replaces one IIR filter instance per channel.

## Interface
- NCH, 4, number of channels (2..8)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NCH  channel i has a sample on x_in[4i+3:4i]
- req_ready  output  NCH  one-hot grant; handshake completes when valid&ready
- x_in  input  4*NCH  per-channel 4-bit two's-complement sample
- cfg_we  input  1  coefficient write strobe
- cfg_ch  input  3  coefficient write channel index (values >= NCH ignored)
- cfg_a  input  4  signed coefficient
- out_valid  output  1  one-cycle result strobe
- out_ch  output  3  channel of current result
- out_y  output  4  new y for out_ch
- busy  output  1  FSM not in IDLE

## Operation
- State per channel: coef[i] (4b signed), ystate[i] (4b signed); both 0 after reset.
- FSM states and transitions:
  - IDLE -> GRANT on any req_valid.
  - GRANT -> MUL.
  - MUL -> ACC.
  - ACC -> IDLE.
- GRANT:
  - Selected channel g is the first i with req_valid[i], searching from rr_ptr upward and wrapping.
  - req_ready[g]=1 for this cycle only; latch x_in[g] and g.
  - rr_ptr <= (g+1) mod NCH.
- MUL: p = coef[g] * ystate[g], 8-bit signed full product, registered.
- ACC:
  - Sum = x + p[3:0], 4-bit wrap-around.
  - ystate[g] <= sum; out_valid=1, out_ch=g, out_y=sum.
- req_ready is 0 in every other state and for every non-granted channel.
- Requesters hold x_in and req_valid stable until their handshake.
- A requester dropping valid before grant is legal; that channel is not served.
- cfg write:
  - Updates coef[cfg_ch] at the clock edge, in any state.
  - The coefficient is sampled on entry to MUL. A write in the same cycle as the GRANT->MUL edge is used by that multiply; a later write is used by the next sample.
- Coefficient writes never disturb ystate.
- Reset, asynchronous, at any time:
  - FSM -> IDLE; rr_ptr, coef, ystate -> 0.
  - Every output -> 0: req_ready, out_valid, out_ch, out_y, busy.
  - Any in-flight sample is dropped without a result.

## Timing
- Handshake at cycle T (GRANT). Multiply registered at T+1 (MUL). out_valid asserted during T+2 (ACC).
- Earliest next grant at T+4: IDLE occupies T+3.
- Peak throughput: one sample per 4 cycles, shared across all channels.
- out_y, out_ch hold their last values after out_valid drops.
- busy=1 in GRANT, MUL, ACC.
- Simultaneous requests: exactly one grant per GRANT state. Each waiting channel is served within NCH grants.

## Configuration
- IIR_SAT_EN defined:
  - The product is clamped to [-8,7] before the add.
  - The sum is computed at 5 bits and clamped to [-8,7].
  - The clamped value is written to ystate and out_y.
- IIR_SAT_EN undefined:
  - Low product nibble p[3:0] is used.
  - The sum wraps modulo 16.

## Test plan
- Reset mid-MUL:
  - Stimulus: assert rst asynchronously during MUL.
  - Response: all outputs 0 immediately, no out_valid afterwards, and ystate re-reads as 0.
  - Check ystate by driving the channel with a=1, x=0: the result is out_y=0.
- Recurrence, wrap build (coef[0]=2, x=1 four times):
  - out_y sequence 1, 3, 7, 4'hF.
  - The 4th step gives product 14, p[3:0]=-2, sum -1.
- Recurrence, IIR_SAT_EN build (same stimulus):
  - out_y sequence 1, 3, 7, 7.
- Negative coefficient:
  - Stimulus: coef[1]=4'hF (-1); x=3 then x=0.
  - Response: out_y=3, then 4'hD (-3).
- Arbitration:
  - Stimulus: all 4 channels valid from cycle 0 after reset.
  - Response: grants to 0, 1, 2, 3 at cycles 0, 4, 8, 12. Each out_valid is 2 cycles after its grant, with matching out_ch.
  - Then re-raise ch2 and ch0 together: ch0 is granted first, since rr_ptr=0.
- cfg/MUL race:
  - Stimulus: coef[0]=1, ystate[0]=2, x=0. Write cfg_a=3 in the GRANT cycle.
  - Response: out_y=6.
  - Writing cfg_a=3 in the MUL cycle instead gives out_y=2.
